// File: rtl/psum_axis_packer_pkg.sv
// -----------------------------------------------------------------------------
// psum_axis_packer_pkg
//   Shared definitions for the partial-sum AXI4-Stream packer:
//   - default geometry of the psum vector and of the output stream
//   - width of the frame counter reported to the status register
//   - FSM state encoding (IDLE = 0, SEND = 1)
// -----------------------------------------------------------------------------
package psum_axis_packer_pkg;

    // Default geometry: 64 lanes of 20-bit signed psums, 32-bit stream.
    localparam int PSUM_NUM_DEF             = 64;
    localparam int PSUM_WIDTH_DEF           = 20;
    localparam int C_M_AXIS_TDATA_WIDTH_DEF = 32;
    localparam int IDX_WIDTH_DEF            = 6;

    // Frame counter width; the counter wraps silently.
    localparam int FRAME_CNT_WIDTH = 16;

    // Packer FSM encoding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } pk_state_e;

endpackage : psum_axis_packer_pkg

// File: rtl/psum_lane_fmt.sv
// -----------------------------------------------------------------------------
// psum_lane_fmt
//   Combinational lane formatter: takes one signed psum lane and produces the
//   stream word. The lane is sign-extended to the stream width; when ReLU is
//   enabled a negative lane (MSB set) becomes zero. The output is never
//   narrower than the lane, so no saturation is needed.
//
// Ports:
//   lane   in   PSUM_WIDTH   signed psum lane
//   relu   in   1            clamp negative lanes to zero
//   tdata  out  DATA_WIDTH   formatted stream word
// -----------------------------------------------------------------------------
module psum_lane_fmt
    import psum_axis_packer_pkg::*;
#(
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int DATA_WIDTH = C_M_AXIS_TDATA_WIDTH_DEF
) (
    input  logic [PSUM_WIDTH-1:0] lane,
    input  logic                  relu,
    output logic [DATA_WIDTH-1:0] tdata
);

    logic signed [PSUM_WIDTH-1:0] lane_s;

    assign lane_s = $signed(lane);

    always_comb begin
        tdata = '0;
        if (!(relu && lane[PSUM_WIDTH-1])) begin
            // Size cast of a signed value sign-extends; this also works when
            // the two widths are equal.
            tdata = DATA_WIDTH'(lane_s);
        end
    end

endmodule : psum_lane_fmt

// File: rtl/psum_axis_packer.sv
// -----------------------------------------------------------------------------
// psum_axis_packer
//   Captures a complete partial-sum vector from the convolution datapath into
//   a shadow buffer and serialises it one lane per beat onto an AXI4-Stream
//   master, with optional per-frame ReLU. TLAST marks the final lane; a
//   one-cycle frame_done pulse and a wrapping frame counter feed the status
//   register.
//
// Handshakes:
//   Input side : a vector is captured on any rising edge where
//                psum_valid & psum_ready. psum_ready is high only in IDLE,
//                so the producer must hold psum_in until it sees the capture.
//   Output side: a beat transfers on any rising edge where
//                M_AXIS_TVALID & M_AXIS_TREADY. While TVALID is high and
//                TREADY low, TDATA/TLAST stay stable and the lane index holds.
//                TVALID stays high from the first to the last beat of a frame.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   psum_valid       in   psum_in holds a complete result vector
//   psum_in          in   packed lanes, lane k = [k*PSUM_WIDTH +: PSUM_WIDTH]
//   psum_ready       out  packer can capture a vector this cycle
//   relu_en          in   clamp negative lanes; sampled at capture
//   M_AXIS_TVALID    out  stream beat valid
//   M_AXIS_TDATA     out  sign-extended (or ReLU'd) lane
//   M_AXIS_TSTRB     out  all ones
//   M_AXIS_TLAST     out  last lane of the frame
//   M_AXIS_TREADY    in   downstream accepts beat
//   frame_done       out  one-cycle pulse after the final beat handshake
//   frame_count      out  frames fully sent since reset (wraps)
// -----------------------------------------------------------------------------
module psum_axis_packer
    import psum_axis_packer_pkg::*;
#(
    parameter int PSUM_NUM             = PSUM_NUM_DEF,
    parameter int PSUM_WIDTH           = PSUM_WIDTH_DEF,
    parameter int C_M_AXIS_TDATA_WIDTH = C_M_AXIS_TDATA_WIDTH_DEF,
    parameter int IDX_WIDTH            = IDX_WIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,

    input  logic                                psum_valid,
    input  logic [PSUM_NUM*PSUM_WIDTH-1:0]      psum_in,
    output logic                                psum_ready,
    input  logic                                relu_en,

    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY,

    output logic                                frame_done,
    output logic [FRAME_CNT_WIDTH-1:0]          frame_count
);

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(PSUM_NUM - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    pk_state_e                       state_q;
    logic [IDX_WIDTH-1:0]            idx_q;
    logic                            relu_q;
    logic                            frame_done_q;
    logic [FRAME_CNT_WIDTH-1:0]      frame_cnt_q;
    logic [PSUM_NUM*PSUM_WIDTH-1:0]  shadow_q;

    logic                            is_last;
    logic                            beat_fire;
    logic                            capture;
    logic [PSUM_WIDTH-1:0]           lane_sel;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] lane_word;

    assign is_last   = (idx_q == IDX_LAST);
    assign capture   = (state_q == ST_IDLE) && psum_valid;
    assign beat_fire = (state_q == ST_SEND) && M_AXIS_TREADY;

    // -------------------------------------------------------------------------
    // Shadow buffer. Written only at capture, so the frame in flight is immune
    // to psum_in changing afterwards. Pure datapath: no reset needed, since
    // nothing reads it outside SEND.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (capture) begin
            shadow_q <= psum_in;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM. relu_en is latched with the vector so that toggling it
    // mid-frame has no effect.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            relu_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (psum_valid) begin
                        relu_q  <= relu_en;
                        idx_q   <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (beat_fire) begin
                        if (is_last) begin
                            // Done pulse and count step land on the same edge,
                            // so the status view never sees one without the other.
                            state_q      <= ST_IDLE;
                            idx_q        <= '0;
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Lane select and formatting. TDATA is a mux of registered state only
    // (shadow, idx, relu), so it is stable whenever idx holds during a stall.
    // -------------------------------------------------------------------------
    assign lane_sel = shadow_q[idx_q * PSUM_WIDTH +: PSUM_WIDTH];

    psum_lane_fmt #(
        .PSUM_WIDTH (PSUM_WIDTH),
        .DATA_WIDTH (C_M_AXIS_TDATA_WIDTH)
    ) u_lane_fmt (
        .lane  (lane_sel),
        .relu  (relu_q),
        .tdata (lane_word)
    );

    // -------------------------------------------------------------------------
    // Outputs. All are decodes of registers; async reset forces IDLE, which
    // drops TVALID/TLAST and zeroes TDATA immediately.
    // -------------------------------------------------------------------------
    assign psum_ready    = (state_q == ST_IDLE);
    assign M_AXIS_TVALID = (state_q == ST_SEND);
    assign M_AXIS_TLAST  = (state_q == ST_SEND) && is_last;
    assign M_AXIS_TDATA  = (state_q == ST_SEND) ? lane_word : '0;
    assign M_AXIS_TSTRB  = '1;
    assign frame_done    = frame_done_q;
    assign frame_count   = frame_cnt_q;

endmodule : psum_axis_packer

// File: tb/tb_psum_axis_packer.sv
// -----------------------------------------------------------------------------
// tb_psum_axis_packer
//   Directed sequence with randomized data and back-pressure. A queue of
//   expected beats is built from the captured vector with plain signed
//   arithmetic; beats are popped only on observed handshakes.
// -----------------------------------------------------------------------------
module tb_psum_axis_packer;

    localparam int PSUM_NUM   = 64;
    localparam int PSUM_WIDTH = 20;
    localparam int DW         = 32;
    localparam int VW         = PSUM_NUM * PSUM_WIDTH;
    localparam int CYC_LIMIT  = 2000;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic            clk = 1'b0;
    logic            rst_n;
    logic            psum_valid;
    logic [VW-1:0]   psum_in;
    logic            psum_ready;
    logic            relu_en;
    logic            M_AXIS_TVALID;
    logic [DW-1:0]   M_AXIS_TDATA;
    logic [DW/8-1:0] M_AXIS_TSTRB;
    logic            M_AXIS_TLAST;
    logic            M_AXIS_TREADY;
    logic            frame_done;
    logic [15:0]     frame_count;

    always #5 clk = ~clk;

    psum_axis_packer #(
        .PSUM_NUM             (PSUM_NUM),
        .PSUM_WIDTH           (PSUM_WIDTH),
        .C_M_AXIS_TDATA_WIDTH (DW),
        .IDX_WIDTH            (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .psum_valid    (psum_valid),
        .psum_in       (psum_in),
        .psum_ready    (psum_ready),
        .relu_en       (relu_en),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .frame_done    (frame_done),
        .frame_count   (frame_count)
    );

    // ---------------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------------
    logic [DW-1:0] exp_q[$];
    logic [15:0]   exp_cnt;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: each lane as a signed integer, then the output rule.
    function automatic int lane_val(input logic [VW-1:0] vec, input int k);
        logic signed [PSUM_WIDTH-1:0] l;
        l = vec[k*PSUM_WIDTH +: PSUM_WIDTH];
        return int'(l);
    endfunction

    task automatic load_model(input logic [VW-1:0] vec, input bit relu);
        int v;
        exp_q.delete();
        for (int k = 0; k < PSUM_NUM; k++) begin
            v = lane_val(vec, k);
            if (relu && v < 0) exp_q.push_back('0);
            else               exp_q.push_back(DW'(v));
        end
    endtask

    function automatic logic [VW-1:0] ramp_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < PSUM_NUM; k++) v[k*PSUM_WIDTH +: PSUM_WIDTH] = PSUM_WIDTH'(k - 32);
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < PSUM_NUM; k++) v[k*PSUM_WIDTH +: PSUM_WIDTH] = PSUM_WIDTH'($urandom);
        return v;
    endfunction

    // ---------------------------------------------------------------------
    // Drivers (called at a negedge)
    // ---------------------------------------------------------------------
    task automatic present(input logic [VW-1:0] vec, input bit relu);
        psum_in    = vec;
        relu_en    = relu;
        psum_valid = 1'b1;
        load_model(vec, relu);
        chk("ready_before_capture", 32'(psum_ready), 32'd1);
    endtask

    // Capture on the next posedge, then drain one frame with TREADY high
    // pct% of the time. Ends at the negedge of the IDLE cycle after the frame.
    task automatic drain(input int pct, input bit keep_valid,
                         input int chg_beat, input logic [VW-1:0] chg_vec);
        int beat = 0;
        int cyc  = 0;
        bit hs;
        @(posedge clk);
        @(negedge clk);
        if (!keep_valid) psum_valid = 1'b0;
        relu_en = ~relu_en;
        while (beat < PSUM_NUM && cyc < CYC_LIMIT) begin
            M_AXIS_TREADY = ($urandom_range(1, 100) <= pct);
            if (beat == chg_beat) psum_in = chg_vec;
            chk("tvalid", 32'(M_AXIS_TVALID), 32'd1);
            chk($sformatf("tdata_beat%0d", beat), M_AXIS_TDATA, exp_q[0]);
            chk("tlast", 32'(M_AXIS_TLAST), 32'(beat == PSUM_NUM - 1));
            chk("ready_in_send", 32'(psum_ready), 32'd0);
            chk("no_early_done", 32'(frame_done), 32'd0);
            hs = M_AXIS_TREADY;
            @(posedge clk);
            if (hs) begin
                void'(exp_q.pop_front());
                beat++;
            end
            cyc++;
            @(negedge clk);
        end
        if (cyc >= CYC_LIMIT) chk("frame_timeout", 32'(beat), 32'(PSUM_NUM));
        M_AXIS_TREADY = 1'b1;
        exp_cnt++;
        chk("frame_done_pulse", 32'(frame_done), 32'd1);
        chk("frame_count", 32'(frame_count), 32'(exp_cnt));
        chk("tvalid_idle", 32'(M_AXIS_TVALID), 32'd0);
        chk("tlast_idle", 32'(M_AXIS_TLAST), 32'd0);
        chk("ready_idle", 32'(psum_ready), 32'd1);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("frame_done_single", 32'(frame_done), 32'd0);
        chk("count_stable", 32'(frame_count), 32'(exp_cnt));
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        logic [VW-1:0] va;
        logic [VW-1:0] vb;
        rst_n         = 1'b0;
        psum_valid    = 1'b0;
        psum_in       = '0;
        relu_en       = 1'b0;
        M_AXIS_TREADY = 1'b1;
        exp_cnt       = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(psum_ready), 32'd1);
        chk("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        chk("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
        chk("rst_tdata", M_AXIS_TDATA, 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);
        chk("tstrb", 32'(M_AXIS_TSTRB), 32'hF);
        rst_n = 1'b1;
        @(negedge clk);

        // Ramp k-32, no ReLU, full throughput
        present(ramp_vec(), 1'b0);
        chk("ramp_ref_beat0", exp_q[0], 32'hFFFF_FFE0);
        chk("ramp_ref_beat63", exp_q[PSUM_NUM-1], 32'h0000_001F);
        drain(100, 1'b0, -1, '0);
        idle_cycle();

        // Same ramp with ReLU
        present(ramp_vec(), 1'b1);
        drain(100, 1'b0, -1, '0);
        idle_cycle();

        // Random data, ~50% back-pressure, both ReLU settings
        for (int f = 0; f < 3; f++) begin
            present(rand_vec(), 1'(f % 2));
            drain(50, 1'b0, -1, '0);
            idle_cycle();
        end

        // psum_valid held, psum_in changes at beat 10: back-to-back capture
        va = rand_vec();
        vb = rand_vec();
        present(va, 1'b0);
        drain(100, 1'b1, 10, vb);
        relu_en = 1'b0;
        load_model(vb, 1'b0);
        drain(100, 1'b0, -1, '0);
        idle_cycle();

        // Reset mid-frame at beat 20
        present(rand_vec(), 1'b0);
        @(posedge clk);
        @(negedge clk);
        psum_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_reset_beat20", M_AXIS_TDATA, exp_q[20]);
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        chk("async_rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        chk("async_rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
        chk("async_rst_done", 32'(frame_done), 32'd0);
        chk("async_rst_count", 32'(frame_count), 32'd0);
        chk("async_rst_ready", 32'(psum_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_cycle();
        present(rand_vec(), 1'b1);
        drain(70, 1'b0, -1, '0);
        idle_cycle();

        // Counter wrap 65535 -> 0
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        @(negedge clk);
        exp_cnt = 16'hFFFF;
        chk("count_preload", 32'(frame_count), 32'h0000_FFFF);
        present(rand_vec(), 1'b0);
        drain(100, 1'b0, -1, '0);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_psum_axis_packer
